// File: rtl/ft_fault_manager_if.sv
// Command and event-log handshake bundle between ft_fault_manager and its debug/CSR host.
interface ft_fault_manager_if #(
    parameter int UNIT_W = 2
);
    // valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
    // the sender holds valid and its payload stable until that edge.
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [UNIT_W-1:0] cmd_unit_i;
    logic [1:0]        cmd_block_i;
    logic              cmd_done_o;
    logic              cmd_err_o;
    logic              log_valid_o;
    logic              log_ready_i;
    logic [UNIT_W+4:0] log_data_o;
    logic              log_overflow_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_block_i, log_ready_i,
        input  cmd_ready_o, cmd_done_o, cmd_err_o, log_valid_o, log_data_o, log_overflow_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_block_i, log_ready_i,
        output cmd_ready_o, cmd_done_o, cmd_err_o, log_valid_o, log_data_o, log_overflow_o
    );
endinterface

// File: rtl/ft_fault_manager.sv
// Supervisor for triplicated FT units: error statistics, merged event log and a
// force/release command engine driving the breakage-monitor set_broken masks.
module ft_fault_manager #(
    parameter int N_UNITS     = 4,
    parameter int UNIT_W      = 2,
    parameter int CNT_W       = 8,
    parameter int LOG_DEPTH   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_UNITS-1:0]     err_detected_i,
    input  logic [N_UNITS-1:0]     err_corrected_i,
    input  logic [3*N_UNITS-1:0]   is_broken_i,
    output logic [3*N_UNITS-1:0]   set_broken_o,
    ft_fault_manager_if.slave      bus,
    output logic [CNT_W-1:0]       err_cnt_o,
    output logic [CNT_W-1:0]       uncorr_cnt_o,
    output logic [1:0]             fsm_state
);
    localparam int N_ENT = 3 * N_UNITS;
    localparam int LOG_W = UNIT_W + 5;
    localparam int AW    = $clog2(LOG_DEPTH);
    localparam int TW    = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, APPLY, WAIT_ACK, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [UNIT_W-1:0]   unit_q;
    logic [1:0]          block_q;
    logic                err_q;
    logic [TW-1:0]       timer_q;
    logic [3*N_UNITS-1:0] tgt_onehot;
    logic                ack, cmd_legal, unit_ok, clear_stats;

    logic [3*N_UNITS-1:0] broken_q, rise, fall;
    logic [N_UNITS-1:0]  uncorr;
    // Pending entry e = 3*unit + kind, so ascending e is exactly the push priority.
    logic [N_ENT-1:0]    pend_q, ev_hit, sel_clr;
    logic [2:0]          mask_q  [N_ENT];
    logic [2:0]          ev_mask [N_ENT];
    logic                found;
    logic [LOG_W-1:0]    sel_data;

    logic [LOG_W-1:0]    fifo_mem [LOG_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push, pop, drop;

    assign fsm_state   = state_q;
    assign clear_stats = (state_q == APPLY) && (op_q == 2'b10);

    always_comb begin
        rise   = is_broken_i & ~broken_q;
        fall   = ~is_broken_i & broken_q;
        uncorr = err_detected_i & ~err_corrected_i;
        ev_hit = '0;
        for (int e = 0; e < N_ENT; e++) ev_mask[e] = 3'b000;
        for (int u = 0; u < N_UNITS; u++) begin
            ev_hit[3*u]      = uncorr[u];
            ev_hit[3*u+1]    = |rise[3*u +: 3];
            ev_mask[3*u+1]   = rise[3*u +: 3];
            ev_hit[3*u+2]    = |fall[3*u +: 3];
            ev_mask[3*u+2]   = fall[3*u +: 3];
        end
    end

    always_comb begin
        found    = 1'b0;
        sel_clr  = '0;
        sel_data = '0;
        for (int e = 0; e < N_ENT; e++) begin
            if (pend_q[e] && !found) begin
                found      = 1'b1;
                sel_clr[e] = 1'b1;
                sel_data   = {2'(e % 3), UNIT_W'(e / 3), mask_q[e]};
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO only drops when not draining.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && bus.log_ready_i;
    assign push       = found && (!fifo_full || pop);
    assign drop       = found && fifo_full && !pop;

    assign bus.log_valid_o = !fifo_empty;
    assign bus.log_data_o  = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= sel_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            broken_q           <= '0;
            pend_q             <= '0;
            bus.log_overflow_o <= 1'b0;
            for (int e = 0; e < N_ENT; e++) mask_q[e] <= 3'b000;
        end else begin
            broken_q <= is_broken_i;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // An entry leaving this cycle restarts from only the events seen now.
            for (int e = 0; e < N_ENT; e++) begin
                if (sel_clr[e]) begin
                    pend_q[e] <= ev_hit[e];
                    mask_q[e] <= ev_mask[e];
                end else begin
                    pend_q[e] <= pend_q[e] | ev_hit[e];
                    mask_q[e] <= mask_q[e] | ev_mask[e];
                end
            end
            if (clear_stats)  bus.log_overflow_o <= 1'b0;
            else if (drop)    bus.log_overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            err_cnt_o    <= '0;
            uncorr_cnt_o <= '0;
        end else begin
            if (|err_detected_i && err_cnt_o != '1)  err_cnt_o    <= err_cnt_o + 1'b1;
            if (|uncorr && uncorr_cnt_o != '1)       uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
        end
    end

    always_comb begin
        unit_ok    = 1'b0;
        tgt_onehot = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (bus.cmd_unit_i == UNIT_W'(u)) unit_ok = 1'b1;
            for (int b = 0; b < 3; b++) begin
                if (unit_q == UNIT_W'(u) && block_q == 2'(b)) tgt_onehot[3*u+b] = 1'b1;
            end
        end
        cmd_legal = bus.cmd_op_i[1] || (unit_ok && bus.cmd_block_i != 2'd3);
        ack       = |(is_broken_i & tgt_onehot);
    end

    always_comb begin
        state_d         = state_q;
        bus.cmd_ready_o = 1'b0;
        bus.cmd_done_o  = 1'b0;
        bus.cmd_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready_o = 1'b1;
                if (bus.cmd_valid_i) state_d = cmd_legal ? APPLY : DONE;
            end
            APPLY:    state_d = (op_q == 2'b00) ? WAIT_ACK : DONE;
            WAIT_ACK: if (ack || timer_q == TW'(ACK_TIMEOUT - 1)) state_d = DONE;
            DONE: begin
                bus.cmd_done_o = 1'b1;
                bus.cmd_err_o  = err_q;
                state_d        = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 2'b00;
            unit_q       <= '0;
            block_q      <= 2'b00;
            err_q        <= 1'b0;
            timer_q      <= '0;
            set_broken_o <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.cmd_valid_i) begin
                    op_q    <= bus.cmd_op_i;
                    unit_q  <= bus.cmd_unit_i;
                    block_q <= bus.cmd_block_i;
                    err_q   <= !cmd_legal;
                end
                APPLY: begin
                    timer_q <= '0;
                    case (op_q)
                        2'b00:   set_broken_o <= set_broken_o | tgt_onehot;
                        2'b01:   set_broken_o <= set_broken_o & ~tgt_onehot;
                        2'b11:   set_broken_o <= '0;
                        default: ;
                    endcase
                end
                WAIT_ACK: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == TW'(ACK_TIMEOUT - 1)) err_q <= !ack;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ft_fault_manager.sv
// Directed bench for ft_fault_manager: event-vector table plus hand-written command,
// overflow, saturation and reset-abort sequences.
module tb_ft_fault_manager;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  err_det = '0;
    logic [3:0]  err_corr = '0;
    logic [11:0] isb = '0;
    logic [11:0] set_broken;
    logic [7:0]  err_cnt, uncorr_cnt;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;
    logic [6:0] exp_q[$];

    ft_fault_manager_if #(.UNIT_W(2)) bus ();

    ft_fault_manager #(
        .N_UNITS(4), .UNIT_W(2), .CNT_W(8), .LOG_DEPTH(8), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .err_detected_i(err_det), .err_corrected_i(err_corr), .is_broken_i(isb),
        .set_broken_o(set_broken), .bus(bus),
        .err_cnt_o(err_cnt), .uncorr_cnt_o(uncorr_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      det;
        logic [3:0]      corr;
        logic [11:0]     isb;
        logic [7:0]      exp_err;
        logic [7:0]      exp_unc;
        logic [2:0]      n_exp;
        logic [4:0][6:0] exp_log;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [6:0] ent(input logic [1:0] kind, input logic [1:0] unit,
                                       input logic [2:0] mask);
        return {kind, unit, mask};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain(input int n, input string tag);
        logic [6:0] e;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            check({tag, " log_valid"}, 32'(bus.log_valid_o), 32'd1);
            check({tag, " log_data"}, 32'(bus.log_data_o), 32'(e));
            bus.log_ready_i = 1'b1;
            tick();
            bus.log_ready_i = 1'b0;
        end
        check({tag, " log empty"}, 32'(bus.log_valid_o), 32'd0);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] unit, input logic [1:0] blk);
        check("cmd_ready before handshake", 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_unit_i  = unit;
        bus.cmd_block_i = blk;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    // Waits (bounded) for the done pulse, then steps back into IDLE.
    task automatic finish_cmd(input string name, input int exp_cycles, input logic exp_err);
        int cycles = -1;
        logic err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.cmd_done_o) begin
                cycles = i;
                err    = bus.cmd_err_o;
                break;
            end
            tick();
        end
        check({name, " done latency"}, 32'(cycles), 32'(exp_cycles));
        check({name, " cmd_err"}, 32'(err), 32'(exp_err));
        tick();
        check({name, " done one cycle"}, 32'(bus.cmd_done_o), 32'd0);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'b00;
        bus.cmd_unit_i  = 2'd0;
        bus.cmd_block_i = 2'd0;
        bus.log_ready_i = 1'b0;

        // Entries are listed with the first-popped entry in the rightmost slot.
        vecs[0] = '{det: 4'b0000, corr: 4'b0000, isb: 12'b000_000_100_001,
                    exp_err: 8'd1, exp_unc: 8'd1, n_exp: 3'd2,
                    exp_log: {7'd0, 7'd0, 7'd0, ent(2'b01, 2'd1, 3'b100), ent(2'b01, 2'd0, 3'b001)}};
        vecs[1] = '{det: 4'b0011, corr: 4'b0001, isb: 12'b000_000_100_010,
                    exp_err: 8'd2, exp_unc: 8'd2, n_exp: 3'd3,
                    exp_log: {7'd0, 7'd0, ent(2'b00, 2'd1, 3'b000), ent(2'b10, 2'd0, 3'b001),
                              ent(2'b01, 2'd0, 3'b010)}};
        vecs[2] = '{det: 4'b1000, corr: 4'b1000, isb: 12'b000_000_000_000,
                    exp_err: 8'd3, exp_unc: 8'd2, n_exp: 3'd2,
                    exp_log: {7'd0, 7'd0, 7'd0, ent(2'b10, 2'd1, 3'b100), ent(2'b10, 2'd0, 3'b010)}};
        vecs[3] = '{det: 4'b0000, corr: 4'b0000, isb: 12'b111_000_000_000,
                    exp_err: 8'd3, exp_unc: 8'd2, n_exp: 3'd1,
                    exp_log: {7'd0, 7'd0, 7'd0, 7'd0, ent(2'b01, 2'd3, 3'b111)}};
        vecs[4] = '{det: 4'b1111, corr: 4'b0000, isb: 12'b000_000_000_000,
                    exp_err: 8'd4, exp_unc: 8'd3, n_exp: 3'd5,
                    exp_log: {ent(2'b10, 2'd3, 3'b111), ent(2'b00, 2'd3, 3'b000),
                              ent(2'b00, 2'd2, 3'b000), ent(2'b00, 2'd1, 3'b000),
                              ent(2'b00, 2'd0, 3'b000)}};

        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("reset set_broken", 32'(set_broken), 32'd0);
        check("reset cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("reset cmd_done", 32'(bus.cmd_done_o), 32'd0);
        check("reset cmd_err", 32'(bus.cmd_err_o), 32'd0);
        check("reset log_valid", 32'(bus.log_valid_o), 32'd0);
        check("reset overflow", 32'(bus.log_overflow_o), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        check("reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        check("reset fsm_state", 32'(fsm_state), 32'd0);

        // Single uncorrectable cycle on unit 2: log appears two edges after the event.
        err_det = 4'b0100;
        tick();
        err_det = 4'b0000;
        check("uncorr u2 log_valid at +1", 32'(bus.log_valid_o), 32'd0);
        check("uncorr u2 err_cnt", 32'(err_cnt), 32'd1);
        check("uncorr u2 uncorr_cnt", 32'(uncorr_cnt), 32'd1);
        tick();
        check("uncorr u2 log_valid at +2", 32'(bus.log_valid_o), 32'd1);
        exp_q.push_back(ent(2'b00, 2'd2, 3'b000));
        drain(1, "uncorr u2");

        for (int r = 0; r < 5; r++) begin
            err_det  = vecs[r].det;
            err_corr = vecs[r].corr;
            isb      = vecs[r].isb;
            tick();
            err_det  = '0;
            err_corr = '0;
            repeat (6) tick();
            check($sformatf("vec%0d err_cnt", r), 32'(err_cnt), 32'(vecs[r].exp_err));
            check($sformatf("vec%0d uncorr_cnt", r), 32'(uncorr_cnt), 32'(vecs[r].exp_unc));
            for (int k = 0; k < int'(vecs[r].n_exp); k++) exp_q.push_back(vecs[r].exp_log[k]);
            drain(int'(vecs[r].n_exp), $sformatf("vec%0d", r));
        end

        // Force unit1 block2, acknowledged three cycles after APPLY.
        send_cmd(2'b00, 2'd1, 2'd2);
        check("force mask before apply", 32'(set_broken), 32'd0);
        check("force cmd_ready low", 32'(bus.cmd_ready_o), 32'd0);
        repeat (3) tick();
        check("force mask set", 32'(set_broken), 32'h020);
        check("force no early done", 32'(bus.cmd_done_o), 32'd0);
        isb = 12'h020;
        finish_cmd("force ack", 1, 1'b0);
        exp_q.push_back(ent(2'b01, 2'd1, 3'b100));

        send_cmd(2'b01, 2'd1, 2'd2);
        finish_cmd("release", 1, 1'b0);
        check("release mask", 32'(set_broken), 32'd0);
        isb = '0;
        exp_q.push_back(ent(2'b10, 2'd1, 3'b100));
        repeat (3) tick();
        drain(2, "force/release log");

        send_cmd(2'b00, 2'd2, 2'd0);
        finish_cmd("force timeout", 17, 1'b1);
        check("timeout mask kept", 32'(set_broken), 32'h040);

        send_cmd(2'b00, 2'd0, 2'd3);
        finish_cmd("illegal block", 0, 1'b1);
        check("illegal mask unchanged", 32'(set_broken), 32'h040);

        send_cmd(2'b11, 2'd0, 2'd0);
        finish_cmd("release all", 1, 1'b0);
        check("release all mask", 32'(set_broken), 32'd0);

        // Ten separated events into an 8-deep log that is not being read.
        for (int i = 0; i < 10; i++) begin
            err_det = 4'(1 << (i % 4));
            tick();
            err_det = '0;
            tick();
            if (i < 8) exp_q.push_back(ent(2'b00, 2'(i % 4), 3'b000));
        end
        repeat (2) tick();
        check("overflow set", 32'(bus.log_overflow_o), 32'd1);
        check("overflow err_cnt", 32'(err_cnt), 32'd14);
        check("overflow uncorr_cnt", 32'(uncorr_cnt), 32'd13);

        send_cmd(2'b10, 2'd0, 2'd0);
        finish_cmd("clear stats", 1, 1'b0);
        check("clear overflow", 32'(bus.log_overflow_o), 32'd0);
        check("clear err_cnt", 32'(err_cnt), 32'd0);
        check("clear uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        drain(8, "retained log");

        err_det = 4'b0001;
        repeat (300) tick();
        err_det = '0;
        tick();
        check("saturate err_cnt", 32'(err_cnt), 32'd255);
        check("saturate uncorr_cnt", 32'(uncorr_cnt), 32'd255);

        // Reset in the middle of a force aborts it silently.
        send_cmd(2'b00, 2'd0, 2'd1);
        tick();
        check("abort mask set", 32'(set_broken), 32'h002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort mask cleared", 32'(set_broken), 32'd0);
        check("abort no done", 32'(bus.cmd_done_o), 32'd0);
        check("abort cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("abort fsm idle", 32'(fsm_state), 32'd0);
        check("abort log empty", 32'(bus.log_valid_o), 32'd0);
        check("abort err_cnt", 32'(err_cnt), 32'd0);
        tick();
        check("abort still no done", 32'(bus.cmd_done_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
